// File: rtl/pos_lifo_stack.sv
// pos_lifo_stack
//   LIFO of per-word POS tags. The Viterbi argmax stage pushes one tag per
//   word during the forward pass. The output sequencer pops them in reverse
//   order during backtrace.
//
// Ports
//   CLK        rising-edge clock
//   reset      synchronous, active-high reset
//   clear      synchronous flush: empties the stack and clears the error flags
//   push       write din on top of the stack this cycle
//   pop        remove the top entry this cycle
//   din        [DW-1:0] tag to push
//   dout       [DW-1:0] registered popped tag, held between pops
//   dout_valid one-cycle strobe: dout holds newly popped data
//   count      [AW:0] occupancy, 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
//   overflow   sticky: a push was dropped because the stack was full
//   underflow  sticky: a pop was dropped because the stack was empty
//   done       one-cycle pulse when a pop drains the stack (count 1 -> 0)
module pos_lifo_stack #(
  parameter  int DW    = 4,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow,
  output logic          done
);

  localparam logic [AW:0] COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic [AW:0]   count_m1;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;
  logic          pop_ok;
  logic          push_ok;
  logic          wr_en;

  // empty/full are decoded from the registered count only, so there is no
  // combinational path from the strobes to these flags.
  assign empty = (count == '0);
  assign full  = (count == COUNT_FULL);

  // Top of stack is count-1. Its value is only used when the stack is non-empty.
  assign count_m1 = count - COUNT_ONE;
  assign top_idx  = count_m1[AW-1:0];

  // NOTE: always_comb uses blocking assignments, and every output gets a
  // default first. This keeps the block purely combinational and avoids an
  // inferred latch.
  always_comb begin
    pop_ok  = 1'b0;
    push_ok = 1'b0;
    wr_idx  = count[AW-1:0];
    pop_ok  = pop && !empty;
    // A simultaneous pop frees the top slot, so a push into a full stack
    // replaces the top instead of overflowing.
    push_ok = push && (!full || pop_ok);
    if (pop_ok) begin
      wr_idx = top_idx;
    end
  end

  assign wr_en = push_ok && !reset && !clear;

  // NOTE: the storage array has no reset because its contents are don't-care
  // after reset. Keeping it reset-free lets it map onto plain RAM/regfile
  // cells. Reset and clear only suppress the write.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_idx] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge values.
  always_ff @(posedge CLK) begin
    if (reset) begin
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      done       <= 1'b0;
    end else if (clear) begin
      // A flush discards any push/pop in the same cycle. dout is held.
      count      <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      done       <= 1'b0;
    end else begin
      dout_valid <= pop_ok;
      done       <= pop_ok && !push_ok && (count == COUNT_ONE);

      if (pop_ok) begin
        dout <= mem[top_idx];
      end

      if (push_ok && !pop_ok) begin
        count <= count + COUNT_ONE;
      end else if (pop_ok && !push_ok) begin
        count <= count_m1;
      end

      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      if (pop && !pop_ok) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
